stdlib_packet_router: RTL and testbench

//  Companion of the fixed-priority arbiter, opposite direction: one decoupled input stream is

---
 rtl/stdlib_packet_router.sv | 105 ++++++++++
 tb/tb_stdlib_packet_router.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdlib_packet_router.sv
// Steers one decoupled input stream to one of N output register slices by destination index.
// Multi-beat packets stay locked to the destination of their first beat.
module stdlib_packet_router #(
   parameter int WIDTH  = 8,
   parameter int N      = 4,
   parameter int DEST_W = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 io_in_valid,
   output logic                 io_in_ready,
   input  logic [WIDTH-1:0]     io_in_bits,
   input  logic [DEST_W-1:0]    io_in_dest,
   input  logic                 io_in_last,
   output logic [N-1:0]         io_out_valid,
   input  logic [N-1:0]         io_out_ready,
   output logic [N*WIDTH-1:0]   io_out_bits,
   output logic                 io_busy,
   output logic                 io_err
);

   localparam logic [DEST_W:0] NUM_PORTS = (DEST_W + 1)'(N);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t              state_q, state_d;
   logic [DEST_W-1:0]   lock_q, lock_d;
   logic [DEST_W-1:0]   target;
   logic                in_range;
   logic                slot_free;
   logic                fire;
   logic                err_q;
   logic [N-1:0]        valid_q;

   // Out-of-range targets are always ready so the beat is swallowed instead of stalling the input.
   always_comb begin
      target    = (state_q == LOCKED) ? lock_q : io_in_dest;
      in_range  = ({1'b0, target} < NUM_PORTS);
      slot_free = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (target == DEST_W'(k)) begin
            slot_free = !valid_q[k] || io_out_ready[k];
         end
      end
      io_in_ready = !in_range || slot_free;
      fire        = io_in_valid && io_in_ready;
   end

   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      if (fire) begin
         if (io_in_last) begin
            state_d = IDLE;
         end else if (state_q == IDLE) begin
            state_d = LOCKED;
            lock_d  = io_in_dest;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         lock_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         err_q   <= fire && !in_range;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slice
      logic             load;
      logic             slice_valid;
      logic [WIDTH-1:0] slice_bits;

      assign load = fire && in_range && (target == DEST_W'(k));

      // A load in the same cycle as a drain keeps the slice full with the new beat.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            slice_valid <= 1'b0;
            slice_bits  <= '0;
         end else if (load) begin
            slice_valid <= 1'b1;
            slice_bits  <= io_in_bits;
         end else if (slice_valid && io_out_ready[k]) begin
            slice_valid <= 1'b0;
         end
      end

      assign valid_q[k]                      = slice_valid;
      assign io_out_bits[k*WIDTH +: WIDTH]   = slice_bits;
   end

   assign io_out_valid = valid_q;
   assign io_busy      = (state_q == LOCKED);
   assign io_err       = err_q;

endmodule

// File: tb/tb_stdlib_packet_router.sv
// Scoreboard bench for stdlib_packet_router: a cycle model predicts handshakes and slice
// occupancy, per-port queues hold the expected data; a second N=3 instance covers the drop path.
module tb_stdlib_packet_router;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_bits;
   logic [1:0]  in_dest;
   logic        in_last;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_bits;
   logic        busy;
   logic        err;

   logic        b_valid;
   logic        b_ready;
   logic [7:0]  b_bits;
   logic [1:0]  b_dest;
   logic        b_last;
   logic [2:0]  b_out_valid;
   logic [2:0]  b_out_ready;
   logic [23:0] b_out_bits;
   logic        b_busy;
   logic        b_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] expQ [4][$];
   logic [3:0] mValid;
   logic       mLocked;
   logic [1:0] mLock;
   logic       mErr;

   always #5 clk = ~clk;

   stdlib_packet_router #(.WIDTH(8), .N(4), .DEST_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits),
      .io_in_dest(in_dest), .io_in_last(in_last),
      .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_bits(out_bits),
      .io_busy(busy), .io_err(err)
   );

   stdlib_packet_router #(.WIDTH(8), .N(3), .DEST_W(2)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .io_in_valid(b_valid), .io_in_ready(b_ready), .io_in_bits(b_bits),
      .io_in_dest(b_dest), .io_in_last(b_last),
      .io_out_valid(b_out_valid), .io_out_ready(b_out_ready), .io_out_bits(b_out_bits),
      .io_busy(b_busy), .io_err(b_err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model for the N=4 instance, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      logic [1:0] t;
      logic       mReady;
      logic       fire;
      if (!reset_n) begin
         mValid  = '0;
         mLocked = 1'b0;
         mLock   = '0;
         mErr    = 1'b0;
         for (int k = 0; k < 4; k++) expQ[k].delete();
         checkOutput("rst_out_valid", {28'd0, out_valid}, 32'd0);
         checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
         t      = mLocked ? mLock : in_dest;
         mReady = !mValid[t] || out_ready[t];
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mReady});
         checkOutput("out_valid", {28'd0, out_valid}, {28'd0, mValid});
         checkOutput("busy", {31'd0, busy}, {31'd0, mLocked});
         checkOutput("err", {31'd0, err}, {31'd0, mErr});
         for (int k = 0; k < 4; k++) begin
            if (mValid[k]) begin
               if (expQ[k].size() == 0) begin
                  checkOutput($sformatf("sb_empty%0d", k), 32'd1, 32'd0);
               end else begin
                  checkOutput($sformatf("out%0d_bits", k), {24'd0, out_bits[k*8 +: 8]},
                              {24'd0, expQ[k][0]});
                  if (out_ready[k]) void'(expQ[k].pop_front());
               end
            end
         end
         fire = in_valid && mReady;
         for (int k = 0; k < 4; k++) begin
            if (fire && t == 2'(k)) mValid[k] = 1'b1;
            else if (mValid[k] && out_ready[k]) mValid[k] = 1'b0;
         end
         if (fire) begin
            expQ[t].push_back(in_bits);
            if (mLocked) begin
               if (in_last) mLocked = 1'b0;
            end else if (!in_last) begin
               mLocked = 1'b1;
               mLock   = in_dest;
            end
         end
         mErr = 1'b0;
      end
   end

   // Drives one beat starting just after a rising edge and returns once it has been accepted.
   task automatic applyStimulus(input logic [7:0] bits, input logic [1:0] dest, input logic last);
      int waitCycles;
      in_valid   = 1'b1;
      in_bits    = bits;
      in_dest    = dest;
      in_last    = last;
      waitCycles = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            break;
         end
         waitCycles++;
         if (waitCycles > 50) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      in_bits     = '0;
      in_dest     = '0;
      in_last     = 1'b0;
      out_ready   = 4'hF;
      b_valid     = 1'b0;
      b_bits      = '0;
      b_dest      = '0;
      b_last      = 1'b0;
      b_out_ready = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      checkOutput("reset_valid", {28'd0, out_valid}, 32'd0);
      checkOutput("reset_bits", out_bits, 32'd0);
      checkOutput("reset_err", {31'd0, err}, 32'd0);

      // Single-beat packet lands on port 2 one cycle after acceptance.
      applyStimulus(8'h11, 2'd2, 1'b1);
      in_valid = 1'b0;
      checkOutput("t1_valid", {28'd0, out_valid}, 32'h4);
      checkOutput("t1_bits", {24'd0, out_bits[23:16]}, 32'h11);
      idle(2);

      // Later beats carry a different dest that must be ignored while locked.
      applyStimulus(8'hA0, 2'd1, 1'b0);
      checkOutput("t2_busy", {31'd0, busy}, 32'd1);
      applyStimulus(8'hA1, 2'd3, 1'b0);
      applyStimulus(8'hA2, 2'd3, 1'b1);
      in_valid = 1'b0;
      checkOutput("t2_idle", {31'd0, busy}, 32'd0);
      idle(2);

      // Stalled consumer on port 0, then released for back-to-back delivery.
      out_ready[0] = 1'b0;
      applyStimulus(8'h31, 2'd0, 1'b1);
      in_bits = 8'h32;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t3_stall", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      applyStimulus(8'h32, 2'd0, 1'b1);
      applyStimulus(8'h33, 2'd0, 1'b1);
      applyStimulus(8'h34, 2'd0, 1'b1);
      idle(3);

      // Full slice 3 blocks only beats aimed at it.
      out_ready[3] = 1'b0;
      applyStimulus(8'h40, 2'd3, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(8'h50 + 8'(i), 2'd0, 1'b1);
      in_bits = 8'h41;
      in_dest = 2'd3;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t4_hol", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready[3] = 1'b1;
      applyStimulus(8'h41, 2'd3, 1'b1);
      idle(3);

      // Out-of-range destination on the N=3 instance is consumed and flagged.
      b_valid = 1'b1;
      b_bits  = 8'h55;
      b_dest  = 2'd3;
      b_last  = 1'b0;
      @(negedge clk);
      checkOutput("t5_ready0", {31'd0, b_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("t5_err0", {31'd0, b_err}, 32'd1);
      checkOutput("t5_busy0", {31'd0, b_busy}, 32'd1);
      checkOutput("t5_none0", {29'd0, b_out_valid}, 32'd0);
      b_bits = 8'h56;
      b_dest = 2'd0;
      b_last = 1'b1;
      @(negedge clk);
      checkOutput("t5_ready1", {31'd0, b_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("t5_err1", {31'd0, b_err}, 32'd1);
      checkOutput("t5_busy1", {31'd0, b_busy}, 32'd0);
      checkOutput("t5_none1", {29'd0, b_out_valid}, 32'd0);
      b_bits = 8'h77;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      checkOutput("t5_err2", {31'd0, b_err}, 32'd0);
      checkOutput("t5_valid", {29'd0, b_out_valid}, 32'd1);
      checkOutput("t5_bits", {24'd0, b_out_bits[7:0]}, 32'h77);
      @(posedge clk);
      #1;
      checkOutput("t5_drained", {29'd0, b_out_valid}, 32'd0);

      // Asynchronous reset mid-packet with slices held full.
      out_ready = 4'h0;
      applyStimulus(8'h61, 2'd1, 1'b1);
      applyStimulus(8'h62, 2'd2, 1'b0);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_async_valid", {28'd0, out_valid}, 32'd0);
      checkOutput("t6_async_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 4'hF;
      applyStimulus(8'h71, 2'd0, 1'b0);
      applyStimulus(8'h72, 2'd2, 1'b1);
      idle(4);

      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("sb_left%0d", k), expQ[k].size(), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
